// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller and its flush counter.
package branch_pkg;

    localparam int PC_WIDTH_DEFAULT = 32;
    localparam int CNT_WIDTH        = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

endpackage

// File: rtl/flush_counter.sv
// Loadable down-counter that times the post-redirect flush window.
import branch_pkg::*;

module flush_counter #(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the count parks at zero once it runs out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences PC redirect and F/D, D/X flush after a taken branch resolved in execute.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
import branch_pkg::*;

module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_WIDTH     = PC_WIDTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ctrl_branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                stall_in,
    input  logic                fetch_ready,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush_fd,
    output logic                flush_dx,
    output logic                busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         stat_redirects,
    output logic [31:0]         stat_flush_cycles
`endif
);

    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   handshake;
    logic   flush_done;

    assign accept    = (state == IDLE) && ctrl_branch && !stall_in;
    assign handshake = (state == REDIRECT) && fetch_ready;

    flush_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_flush_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (handshake),
        .load_value (FLUSH_LOAD),
        .enable     ((state == FLUSH) && !stall_in),
        .terminal   (flush_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Wrong-path strobes are dropped simply because only IDLE looks at ctrl_branch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = REDIRECT;
                end
            end
            REDIRECT: begin
                if (handshake) begin
                    next_state = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done && !stall_in) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = 1'b0;
        flush_fd       = 1'b0;
        flush_dx       = 1'b0;
        busy           = 1'b0;
        unique case (state)
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush_fd       = 1'b1;
                flush_dx       = 1'b1;
                busy           = 1'b1;
            end
            FLUSH: begin
                flush_fd = 1'b1;
                flush_dx = 1'b1;
                busy     = 1'b1;
            end
            default: begin
                redirect_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_pc <= '0;
        end else if (accept) begin
            redirect_pc <= branch_target;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_redirects    <= '0;
            stat_flush_cycles <= '0;
        end else begin
            if (handshake) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
            if (flush_fd) begin
                stat_flush_cycles <= stat_flush_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// against a remaining-cycles reference model; define BRANCH_STATS_EN to also check counters.
module tb_branch_redirect_ctrl;

    localparam int FC = 2;
    localparam int PW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          ctrl_branch;
    logic [PW-1:0] branch_target;
    logic          stall_in;
    logic          fetch_ready;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          flush_fd;
    logic          flush_dx;
    logic          busy;
`ifdef BRANCH_STATS_EN
    logic [31:0]   stat_redirects;
    logic [31:0]   stat_flush_cycles;
    logic [31:0]   m_stat_r;
    logic [31:0]   m_stat_f;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: is a redirect outstanding, and how many unstalled flush cycles remain.
    bit            m_redirect;
    int            m_flush_left;
    logic [PW-1:0] m_target;
    logic [PW-1:0] exp_q[$];

    branch_redirect_ctrl #(
        .FLUSH_CYCLES (FC),
        .PC_WIDTH     (PW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_branch    (ctrl_branch),
        .branch_target  (branch_target),
        .stall_in       (stall_in),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_fd       (flush_fd),
        .flush_dx       (flush_dx),
        .busy           (busy)
`ifdef BRANCH_STATS_EN
        ,
        .stat_redirects    (stat_redirects),
        .stat_flush_cycles (stat_flush_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        m_redirect   = 1'b0;
        m_flush_left = 0;
        m_target     = '0;
        exp_q.delete();
`ifdef BRANCH_STATS_EN
        m_stat_r = '0;
        m_stat_f = '0;
`endif
    endtask

    task automatic checkOutput();
        bit fl;
        fl = m_redirect || (m_flush_left > 0);
        compare("status{valid,fd,dx,busy}", 64'({redirect_valid, flush_fd, flush_dx, busy}),
                64'({m_redirect, fl, fl, fl}));
        compare("redirect_pc", 64'(redirect_pc), 64'(m_target));
`ifdef BRANCH_STATS_EN
        compare("stat_redirects", 64'(stat_redirects), 64'(m_stat_r));
        compare("stat_flush_cycles", 64'(stat_flush_cycles), 64'(m_stat_f));
`endif
    endtask

    // One clock: check what the last edge produced, drive new inputs, advance the model.
    task automatic applyStimulus(input logic cb, input logic [PW-1:0] tgt,
                                 input logic st, input logic rdy);
        @(posedge clock);
        #1;
        checkOutput();
        ctrl_branch   = cb;
        branch_target = tgt;
        stall_in      = st;
        fetch_ready   = rdy;
`ifdef BRANCH_STATS_EN
        if (m_redirect || (m_flush_left > 0)) m_stat_f++;
        if (m_redirect && rdy) m_stat_r++;
`endif
        if (m_redirect) begin
            if (rdy) begin
                m_redirect   = 1'b0;
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            if (!st) m_flush_left--;
        end else if (cb && !st) begin
            m_redirect = 1'b1;
            m_target   = tgt;
            exp_q.push_back(tgt);
        end
    endtask

    // Monitor: every handshake must deliver the oldest accepted target.
    initial begin
        logic [PW-1:0] exp_pc;
        forever begin
            @(negedge clock);
            if (!reset && redirect_valid && fetch_ready) begin
                if (exp_q.size() == 0) begin
                    compare("handshake_expected", 64'(1), 64'(0));
                end else begin
                    exp_pc = exp_q.pop_front();
                    compare("handshake_pc", 64'(redirect_pc), 64'(exp_pc));
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        ctrl_branch   = 1'b0;
        branch_target = '0;
        stall_in      = 1'b0;
        fetch_ready   = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        // Basic redirect with immediate fetch acceptance.
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Fetch back-pressure for four cycles.
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Wrong-path strobe during FLUSH is ignored.
        applyStimulus(1'b1, 32'h0000_0180, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Stall freezes the flush countdown.
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Stalled strobe is taken on the first unstalled cycle.
        repeat (3) applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), PW'($urandom),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
        end

        repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        compare("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset while a redirect is pending.
        applyStimulus(1'b1, 32'h0000_0abc, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        compare("async_reset_outputs", 64'({redirect_valid, flush_fd, flush_dx, busy}), 64'(0));
        compare("async_reset_pc", 64'(redirect_pc), 64'(0));
        @(posedge clock);
        #2;
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the PC redirect and pipeline flush that follow a taken control transfer resolved in execute. Samples the branch unit's ctrl_branch/nextPC pair and hands the target to fetch over a valid/ready handshake. Holds F/D and D/X flush for a programmable number of cycles. Ignores wrong-path branches while a redirect is in flight. Sits between the branch unit, the fetch PC mux and the hazard/stall logic.

Parameters:
FLUSH_CYCLES, 2, cycles flush_fd/flush_dx stay asserted after redirect handshake (0..15)
PC_WIDTH, 32, width of PC/target

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ctrl_branch  input  1  taken-transfer strobe from branch unit (execute stage)
branch_target  input  PC_WIDTH  branch unit nextPC, valid when ctrl_branch=1
stall_in  input  1  pipeline stall (hazard/multdiv); freezes sampling and flush count
fetch_ready  input  1  fetch accepts redirect this cycle
redirect_valid  output  1  redirect_pc valid for fetch
redirect_pc  output  PC_WIDTH  captured target
flush_fd  output  1  squash F/D latch
flush_dx  output  1  squash D/X latch
busy  output  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, redirect_pc=0; all 1-bit outputs 0. Reset mid-redirect/flush abandons the operation immediately.
- All outputs registered or decoded from registered state; no combinational input-to-output path.
- States: IDLE, REDIRECT, FLUSH. Counter: 4 bits.
- IDLE: ctrl_branch=1 and stall_in=0 -> capture branch_target into redirect_pc, go REDIRECT. If stall_in=1, ctrl_branch is not sampled. Stalled pipeline holds the strobe, so it is taken on the first unstalled cycle.
- REDIRECT: redirect_valid=1, flush_fd=1, flush_dx=1. redirect_pc is held stable until the handshake. Handshake = redirect_valid & fetch_ready. stall_in does not block the handshake.
  - On handshake with FLUSH_CYCLES=0 -> IDLE.
  - Otherwise -> FLUSH with counter=FLUSH_CYCLES.
- FLUSH: redirect_valid=0, flush_fd=1, flush_dx=1. Counter decrements on each cycle with stall_in=0. Counter==1 and stall_in=0 -> IDLE, counter=0.
- ctrl_branch in REDIRECT or FLUSH: ignored (wrong-path). redirect_pc is not overwritten.
- IDLE->REDIRECT takes 1 cycle: a strobe at edge N gives redirect_valid high after edge N+1.
- Total flush duration = REDIRECT cycles + FLUSH_CYCLES unstalled cycles.
- busy = (state != IDLE).
- Back-to-back: a strobe in the first IDLE cycle after FLUSH is accepted normally.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Adds outputs stat_redirects [31:0] (+1 per redirect handshake) and stat_flush_cycles [31:0] (+1 per cycle with flush_fd=1).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (branch_pkg): state encoding constants IDLE=2'b00, REDIRECT=2'b01, FLUSH=2'b10; PC_WIDTH default; flush counter width 4.
- One natural sub-module: flush_counter. Loadable down-counter with enable (load value, enable=!stall_in, terminal flag at 1).
- FSM, target capture register and output decode stay in the top module.

Test Plan:
- Strobe ctrl_branch=1, branch_target=0x0000_0040, fetch_ready=1, FLUSH_CYCLES=2 -> redirect_valid=1 with redirect_pc=0x40 for exactly 1 cycle; flush_fd/flush_dx high for 3 cycles total; then busy=0.
- fetch_ready=0 for 4 cycles after strobe with target 0x100 -> redirect_valid held 4 cycles, redirect_pc stable at 0x100. Raise fetch_ready -> handshake, then 2 FLUSH cycles.
- Second strobe (target 0x200) during FLUSH -> ignored; redirect_pc stays at first target, no second redirect, busy drops on schedule.
- stall_in=1 for 3 cycles mid-FLUSH -> counter frozen; flush outputs stay high for 3 extra cycles.
- stall_in=1 concurrent with strobe in IDLE -> no capture. Strobe held into unstalled cycle -> captured next edge.
- Assert reset during REDIRECT -> redirect_valid, flush_fd, flush_dx, busy drop to 0 asynchronously (before next clock edge). With BRANCH_STATS_EN: three completed redirects -> stat_redirects=3, stat_flush_cycles=9.
